// File: rtl/slow_access_timer.sv
// Slow-mode request timer: enters slow mode on an enabled slow-device access and
// holds it for SlowTimeout ticks after the access ends.
module slow_access_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             CLK,
  input  logic             nPOR,
  input  logic             BACT,
  input  logic             IACKCS,
  input  logic             VIACS,
  input  logic             IWMCS,
  input  logic             SCCCS,
  input  logic             SCSICS,
  input  logic             SndCS,
  input  logic             SlowIACK,
  input  logic             SlowVIA,
  input  logic             SlowIWM,
  input  logic             SlowSCC,
  input  logic             SlowSCSI,
  input  logic             SlowSnd,
  input  logic             SlowClockGate,
  input  logic [CNT_W-1:0] SlowTimeout,
  input  logic             TimeoutTick,
  output logic             SlowReq,
  output logic             ClockGate,
  output logic             SlowExpire
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slow_req_q, slow_req_d;
  logic             clock_gate_q, clock_gate_d;
  logic             slow_expire_q, slow_expire_d;
  logic             qual_c;

  assign qual_c = (IACKCS & SlowIACK) | (VIACS  & SlowVIA)  | (IWMCS & SlowIWM) |
                  (SCCCS  & SlowSCC)  | (SCSICS & SlowSCSI) | (SndCS & SlowSnd);

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      slow_req_q    <= 1'b0;
      clock_gate_q  <= 1'b0;
      slow_expire_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      slow_req_q    <= slow_req_d;
      clock_gate_q  <= clock_gate_d;
      slow_expire_q <= slow_expire_d;
    end
  end

  // Next-state and output decision; a new slow access in HOLD beats a same-cycle tick.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    slow_expire_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (BACT && qual_c) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!BACT) begin
          if (SlowTimeout == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = SlowTimeout;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (BACT && qual_c) begin
          state_d = ACCESS;
        end else if (TimeoutTick) begin
          if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            cnt_d         = '0;
            state_d       = IDLE;
            slow_expire_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    slow_req_d   = (state_d != IDLE);
    clock_gate_d = slow_req_d & SlowClockGate;
  end

  assign SlowReq    = slow_req_q;
  assign ClockGate  = clock_gate_q;
  assign SlowExpire = slow_expire_q;

endmodule

// File: doc/slow_access_timer.md
Name: slow_access_timer

Overview:
- Consumer of the slow-mode settings register: reads the per-device Slow* enables, the SlowClockGate enable and the SlowTimeout field.
- Decides when the accelerator must drop to slow (motherboard-speed) operation.
- Holds slow mode for a programmable number of timeout ticks after the last qualifying slow-device access ends, then releases it.
- Sits between the address decoder / bus-access logic and the clock-gating / bus-sync logic.

Parameters:
- CNT_W, 4, width of the hold counter; equals the SlowTimeout field width.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- nPOR  input  1  reset, asynchronous, active-low.
- BACT  input  1  CPU bus access active.
- IACKCS  input  1  interrupt-acknowledge cycle decoded.
- VIACS  input  1  VIA select decoded.
- IWMCS  input  1  IWM select decoded.
- SCCCS  input  1  SCC select decoded.
- SCSICS  input  1  SCSI select decoded.
- SndCS  input  1  sound-buffer access decoded.
- SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd  input  1 each  per-device slow enables from the settings register.
- SlowClockGate  input  1  clock-gate enable from the settings register.
- SlowTimeout  input  CNT_W  hold length in ticks.
- TimeoutTick  input  1  one-CLK strobe, free-running timebase.
- SlowReq  output  1  slow mode requested.
- ClockGate  output  1  gate the fast clock.
- SlowExpire  output  1  one-cycle pulse when a hold ends by timeout.

Behaviour:
- Qual = OR of (IACKCS&SlowIACK, VIACS&SlowVIA, IWMCS&SlowIWM, SCCCS&SlowSCC, SCSICS&SlowSCSI, SndCS&SlowSnd). Combinational, sampled each CLK.
- Reset (nPOR low, asynchronous): state IDLE, Cnt = 0, SlowReq = 0, ClockGate = 0, SlowExpire = 0. If reset is asserted mid-hold, the block returns to IDLE immediately with no SlowExpire pulse.
- States are IDLE, ACCESS and HOLD.
- IDLE:
  - BACT && Qual -> ACCESS.
  - Otherwise stay in IDLE; TimeoutTick is ignored.
- ACCESS:
  - Stay while BACT is high.
  - On the first cycle with BACT low:
    - if SlowTimeout == 0 -> IDLE;
    - else load Cnt = SlowTimeout and go to HOLD.
  - Ticks are ignored in ACCESS.
- HOLD:
  - BACT && Qual -> ACCESS. Cnt is not decremented that cycle; the new access wins over a simultaneous tick.
  - BACT && !Qual (fast access): stay in HOLD and keep counting.
  - TimeoutTick with Cnt > 1: Cnt decrements by 1.
  - TimeoutTick with Cnt == 1: go to IDLE, Cnt = 0, SlowExpire = 1 for exactly the next cycle.
  - Cnt never wraps below 0.
- SlowTimeout is sampled only on the ACCESS->HOLD transition. Changing it during HOLD does not affect the running count.
- Registered outputs, one-cycle latency from the state decision:
  - SlowReq = 1 whenever the next state != IDLE.
  - ClockGate = next SlowReq & SlowClockGate. Clearing SlowClockGate drops ClockGate on the next edge even mid-hold.
- Latency: qualifying access sampled at edge N -> SlowReq high after edge N (visible in cycle N+1).
- A non-enabled device (CS high, Slow* bit 0) never starts slow mode.

Test Plan:
- Reset: hold nPOR low with BACT=1, VIACS=1, SlowVIA=1 -> all outputs 0; release -> SlowReq=1 one cycle later.
- Basic hold: SlowVIA=1, SlowTimeout=3, VIA access for 4 cycles then BACT=0 -> SlowReq stays high until the 3rd TimeoutTick after release. SlowExpire pulses 1 cycle, then SlowReq=0 the same cycle.
- Zero timeout: SlowTimeout=0, SCC access with SlowSCC=1 -> SlowReq falls one cycle after BACT falls; no SlowExpire.
- Disabled device: SlowSCSI=0, SCSI access -> SlowReq/ClockGate stay 0 throughout.
- Re-access during hold: SlowTimeout=5, after 2 ticks a new IWM access (SlowIWM=1) coincident with a tick -> count not decremented. After release, full 5 ticks again before SlowExpire.
- Gate control and mid-hold reset: SlowClockGate 1->0 during HOLD -> ClockGate=0 next cycle, SlowReq unchanged. Then assert nPOR -> immediate IDLE, no SlowExpire.
